// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection, branch squash, global hold,
// WB write-through bypass on captured operands and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W    = 32,
  parameter int ALUCODE_W = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 valid_id,
  input  logic [DATA_W-1:0]    pc4_id,
  input  logic [DATA_W-1:0]    rs_data_id,
  input  logic [DATA_W-1:0]    rt_data_id,
  input  logic [DATA_W-1:0]    imm_id,
  input  logic [4:0]           rs_addr_id,
  input  logic [4:0]           rt_addr_id,
  input  logic [4:0]           rd_addr_id,
  input  logic                 rs_used_id,
  input  logic                 rt_used_id,
  input  logic                 RegWrite_id,
  input  logic                 MemRead_id,
  input  logic                 MemWrite_id,
  input  logic                 MemtoReg_id,
  input  logic                 RegDst_id,
  input  logic                 ALUSrc_id,
  input  logic [ALUCODE_W-1:0] ALUCode_id,
  input  logic                 RegWrite_wb,
  input  logic [4:0]           RegWriteAddr_wb,
  input  logic [DATA_W-1:0]    WriteData_wb,
  output logic                 stall_if_id,
  output logic                 valid_ex,
  output logic [DATA_W-1:0]    pc4_ex,
  output logic [DATA_W-1:0]    rs_data_ex,
  output logic [DATA_W-1:0]    rt_data_ex,
  output logic [DATA_W-1:0]    imm_ex,
  output logic [4:0]           RsAddr_ex,
  output logic [4:0]           RtAddr_ex,
  output logic [4:0]           rd_addr_ex,
  output logic                 RegWrite_ex,
  output logic                 MemRead_ex,
  output logic                 MemWrite_ex,
  output logic                 MemtoReg_ex,
  output logic                 ALUSrc_ex,
  output logic [ALUCODE_W-1:0] ALUCode_ex,
  output logic [4:0]           RegWriteAddr_ex,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    pc4;
    logic [DATA_W-1:0]    rs_data;
    logic [DATA_W-1:0]    rt_data;
    logic [DATA_W-1:0]    imm;
    logic [4:0]           rs_addr;
    logic [4:0]           rt_addr;
    logic [4:0]           rd_addr;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 reg_dst;
    logic                 alu_src;
    logic [ALUCODE_W-1:0] alu_code;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [4:0]       wr_addr_ex_s;
  logic             load_use_s;

  // A WB write to the register being read this cycle must win over the stale file data.
  function automatic logic [DATA_W-1:0] wb_bypass(
    input logic              we,
    input logic [4:0]        wb_addr,
    input logic [DATA_W-1:0] wb_data,
    input logic [4:0]        rd_addr,
    input logic [DATA_W-1:0] rf_data
  );
    if (we && (wb_addr != 5'd0) && (wb_addr == rd_addr)) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

  assign wr_addr_ex_s = ex_q.reg_dst ? ex_q.rd_addr : ex_q.rt_addr;

  // Load in EX whose destination is read by the valid instruction in ID.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_q.mem_read && ex_q.valid && (wr_addr_ex_s != 5'd0) && valid_id) begin
      load_use_s = (rs_used_id && (rs_addr_id == wr_addr_ex_s)) ||
                   (rt_used_id && (rt_addr_id == wr_addr_ex_s));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state selection: hold, then bubble (flush or load-use), then capture.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hold) begin
      ex_d         = ex_q;
      bubble_cnt_d = bubble_cnt_q;
    end else if (flush) begin
      ex_d         = '0;
      bubble_cnt_d = bubble_cnt_q;
    end else if (load_use_s) begin
      ex_d = '0;
      if (bubble_cnt_q == {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q;
      end else begin
        bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ex_d.valid      = valid_id;
      ex_d.pc4        = pc4_id;
      ex_d.rs_data    = wb_bypass(RegWrite_wb, RegWriteAddr_wb, WriteData_wb, rs_addr_id, rs_data_id);
      ex_d.rt_data    = wb_bypass(RegWrite_wb, RegWriteAddr_wb, WriteData_wb, rt_addr_id, rt_data_id);
      ex_d.imm        = imm_id;
      ex_d.rs_addr    = rs_addr_id;
      ex_d.rt_addr    = rt_addr_id;
      ex_d.rd_addr    = rd_addr_id;
      // An empty ID slot enters EX with all control deasserted.
      ex_d.reg_write  = RegWrite_id & valid_id;
      ex_d.mem_read   = MemRead_id  & valid_id;
      ex_d.mem_write  = MemWrite_id & valid_id;
      ex_d.mem_to_reg = MemtoReg_id & valid_id;
      ex_d.reg_dst    = RegDst_id   & valid_id;
      ex_d.alu_src    = ALUSrc_id   & valid_id;
      ex_d.alu_code   = valid_id ? ALUCode_id : {ALUCODE_W{1'b0}};
      bubble_cnt_d    = bubble_cnt_q;
    end
  end

  // Pipeline register and bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // A branch squash removes the consumer itself, so IF/ID need not wait for it.
  assign stall_if_id     = load_use_s & ~flush;

  assign valid_ex        = ex_q.valid;
  assign pc4_ex          = ex_q.pc4;
  assign rs_data_ex      = ex_q.rs_data;
  assign rt_data_ex      = ex_q.rt_data;
  assign imm_ex          = ex_q.imm;
  assign RsAddr_ex       = ex_q.rs_addr;
  assign RtAddr_ex       = ex_q.rt_addr;
  assign rd_addr_ex      = ex_q.rd_addr;
  assign RegWrite_ex     = ex_q.reg_write;
  assign MemRead_ex      = ex_q.mem_read;
  assign MemWrite_ex     = ex_q.mem_write;
  assign MemtoReg_ex     = ex_q.mem_to_reg;
  assign ALUSrc_ex       = ex_q.alu_src;
  assign ALUCode_ex      = ex_q.alu_code;
  assign RegWriteAddr_ex = wr_addr_ex_s;
  assign bubble_cnt      = bubble_cnt_q;

endmodule
